nco_freq_meter: RTL
===================

Name: nco_freq_meter

Overview:
- Measures the frequency of a signed sine sample stream, such as the NCO `fsin_o`/`out_valid` output or an ADC tone, and returns the equivalent NCO phase increment.
- This is the inverse of the NCO: the NCO maps phase increment to sine; this block maps sine back to phase increment.
- Method: counts accepted samples across 2^LOG2NP periods using hysteretic rising zero-crossing detection, then runs a serial restoring divider.
- Uses: closed-loop tuning checks on the effects pedal and self-test of the oscillator path.

Parameters:
- mpr, 16, input sample width (two's complement).
- apr, 32, phase-increment width; same meaning as the NCO accumulator width.
- LOG2NP, 4, log2 of the number of periods averaged per measurement.
- cntw, 24, sample counter width; all-ones value is the timeout.
- hyst, 256, hysteresis threshold magnitude in LSBs; must satisfy 0 < hyst < 2^(mpr-1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  global clock enable; no state changes when low.
- in_valid  in  1  sample qualifier; a sample is accepted when clken && in_valid.
- fsin_i  in  mpr  signed input sample.
- phi_inc_o  out  apr  measured phase increment; held until the next result.
- out_valid  out  1  one-cycle pulse when phi_inc_o/no_sig update.
- no_sig  out  1  set with a result when a timeout occurred; cleared by the next good result.
- busy  out  1  high in DIVIDE.

Behaviour:
- Reset (synchronous, priority over everything, valid in any state including mid-DIVIDE):
  - state=IDLE; phi_inc_o=0, out_valid=0, no_sig=0, busy=0.
  - armed=0, cnt=0, ncross=0, divider cleared.
  - No result is emitted for an aborted measurement.
- Crossing detector (accepted samples only):
  - armed<=1 when fsin_i < -hyst.
  - A crossing occurs when armed && fsin_i >= +hyst; the same cycle clears armed.
  - Samples in (-hyst, +hyst) change nothing.
  - The detector runs in IDLE and MEASURE; it is frozen and cleared in DIVIDE.
- States:
  - IDLE:
    - cnt increments per accepted sample.
    - First crossing -> MEASURE with cnt=0, ncross=0.
    - cnt reaching 2^cntw-1 -> timeout.
  - MEASURE:
    - Each accepted sample increments cnt.
    - A crossing on that sample increments ncross.
    - When ncross reaches 2^LOG2NP, latch D=cnt including the current sample, then go to DIVIDE.
    - cnt reaching 2^cntw-1 first -> timeout.
  - DIVIDE:
    - busy=1; input samples are ignored (dropped).
    - Restoring divide Q = floor(2^(apr+LOG2NP) / D), one quotient bit per cycle with clken=1, taking apr+LOG2NP enabled cycles.
    - Then: phi_inc_o <= Q[apr-1:0], no_sig <= 0, out_valid=1 for one cycle, and go to IDLE (re-sync on next crossing).
  - Saturation: if D <= 2^LOG2NP (not reachable given hysteresis, but guarded), skip the divide; next cycle phi_inc_o = all ones, no_sig=0, out_valid pulse, go to IDLE.
  - Timeout: phi_inc_o <= 0, no_sig <= 1, out_valid pulse, cnt <= 0, stay in or return to IDLE with armed cleared.
- Timing:
  - out_valid asserts on the clock after the final divider iteration.
  - out_valid is a single clk cycle regardless of clken.
  - Outputs are registered; no combinational path from inputs to outputs.
- Width rules:
  - Divider remainder width is cntw+1.
  - The quotient upper LOG2NP bits are discarded; they are zero whenever D > 2^LOG2NP.
- Simultaneous events:
  - Timeout and crossing on the same sample in IDLE: the crossing wins.
  - Timeout and final crossing in MEASURE: the crossing wins (D = 2^cntw-1 is latched).

Test Plan:
- Square-ish tone, period 8 (4x +1000, 4x -1000), in_valid=1, clken=1, defaults -> D=128, phi_inc_o=0x20000000, no_sig=0, exactly one out_valid pulse, busy high for 36 cycles.
- Period 10 (5x +1000, 5x -1000) -> D=160, phi_inc_o=0x19999999.
- Period 2 (alternate +1000/-1000) -> D=32, phi_inc_o=0x80000000.
- Period-8 tone with in_valid toggling 1,0,1,0 and clken low for random cycles -> same 0x20000000 result; no state advance on gated cycles.
- cntw=12, noise within +/-100 (hyst=256) -> after 4095 accepted samples: out_valid pulse, phi_inc_o=0, no_sig=1. A following period-8 tone then gives 0x20000000 with no_sig=0.
- Reset asserted for 1 cycle mid-DIVIDE -> busy=0, phi_inc_o=0, no out_valid for the aborted run. A fresh period-8 tone then yields 0x20000000.

Source files
------------

// File: rtl/nco_freq_meter_if.sv
// nco_freq_meter_if: sample-in / result-out bundle for the NCO frequency meter.
// Ports: clken, in_valid, fsin_i (source side); phi_inc_o, out_valid, no_sig, busy (meter side).
// master modport = sample source / result consumer, slave modport = the meter.
interface nco_freq_meter_if #(
  parameter int mpr = 16,
  parameter int apr = 32
);
  logic                  clken;
  logic                  in_valid;
  logic signed [mpr-1:0] fsin_i;
  logic [apr-1:0]        phi_inc_o;
  logic                  out_valid;
  logic                  no_sig;
  logic                  busy;

  modport master (
    output clken, in_valid, fsin_i,
    input  phi_inc_o, out_valid, no_sig, busy
  );

  modport slave (
    input  clken, in_valid, fsin_i,
    output phi_inc_o, out_valid, no_sig, busy
  );
endinterface

// File: rtl/nco_freq_meter.sv
// nco_freq_meter: measures a sine stream's frequency as the equivalent NCO phase increment.
// Latency: 2^LOG2NP periods of samples, then apr+LOG2NP enabled cycles of serial divide; result pulses one cycle later.
// Backpressure: none; samples arriving while busy (DIVIDE) are dropped.
// Ports: i_clk, i_reset (sync, active-high); i_mtr slave modport carrying clken, in_valid,
//        fsin_i in and phi_inc_o, out_valid, no_sig, busy out. All outputs are registered.
module nco_freq_meter #(
  parameter int mpr    = 16,
  parameter int apr    = 32,
  parameter int LOG2NP = 4,
  parameter int cntw   = 24,
  parameter int hyst   = 256
) (
  input  logic           i_clk,
  input  logic           i_reset,
  nco_freq_meter_if.slave i_mtr
);

  localparam int QW = apr + LOG2NP;
  localparam int BW = $clog2(QW + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEAS = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [cntw-1:0]     CNT_TO  = {cntw{1'b1}};
  localparam logic [cntw-1:0]     D_SAT   = cntw'(1) << LOG2NP;
  localparam logic [LOG2NP:0]     NC_LAST = (LOG2NP+1)'((1 << LOG2NP) - 1);
  localparam logic signed [mpr-1:0] HYST_P = mpr'(hyst);
  localparam logic signed [mpr-1:0] HYST_N = -HYST_P;

  logic [1:0]      r_state;
  logic            r_armed;
  logic [cntw-1:0] r_cnt;
  logic [LOG2NP:0] r_ncross;
  logic [cntw-1:0] r_den;
  logic [cntw:0]   r_rem;
  logic [apr-1:0]  r_quo;
  logic [BW-1:0]   r_bit;
  logic [apr-1:0]  r_phi;
  logic            r_vld;
  logic            r_nosig;
  logic            r_busy;

  logic            w_acc;
  logic            w_neg;
  logic            w_pos;
  logic            w_cross;
  logic [cntw-1:0] w_cnt_inc;
  logic            w_cnt_to;
  logic            w_last;
  logic            w_sat;
  logic [cntw:0]   w_sh;
  logic            w_ge;
  logic [cntw:0]   w_rem_nx;
  logic [apr-1:0]  w_quo_nx;

  assign w_acc     = i_mtr.clken && i_mtr.in_valid;
  assign w_neg     = i_mtr.fsin_i < HYST_N;
  assign w_pos     = i_mtr.fsin_i >= HYST_P;
  assign w_cross   = w_acc && r_armed && w_pos && (r_state != ST_DIV);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cnt_to  = (w_cnt_inc == CNT_TO);
  assign w_last    = (r_ncross == NC_LAST);
  assign w_sat     = (w_cnt_inc <= D_SAT);

  // Restoring divide step. The dividend is a single 1 above the quotient range, consumed
  // by starting the remainder at 1, so every step shifts in a zero. Remainder stays below
  // D, so shifting the full register never loses a significant bit. Only the low apr
  // quotient bits are kept; the discarded upper ones are zero whenever D > 2^LOG2NP.
  assign w_sh     = r_rem << 1;
  assign w_ge     = (w_sh >= {1'b0, r_den});
  assign w_rem_nx = w_ge ? (w_sh - {1'b0, r_den}) : w_sh;
  assign w_quo_nx = (r_quo << 1) | {{(apr-1){1'b0}}, w_ge};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_armed  <= 1'b0;
      r_cnt    <= '0;
      r_ncross <= '0;
      r_den    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_bit    <= '0;
      r_phi    <= '0;
      r_vld    <= 1'b0;
      r_nosig  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // Pulse lasts one clk even when clken is low on the following cycle.
      r_vld <= 1'b0;
      if (i_mtr.clken) begin
        // Hysteretic arm/fire detector; frozen and cleared while dividing.
        if (r_state == ST_DIV) begin
          r_armed <= 1'b0;
        end else if (w_acc) begin
          if (w_neg)        r_armed <= 1'b1;
          else if (w_cross) r_armed <= 1'b0;
        end

        case (r_state)
          ST_IDLE: begin
            if (w_acc) begin
              if (w_cross) begin
                r_state  <= ST_MEAS;
                r_cnt    <= '0;
                r_ncross <= '0;
              end else if (w_cnt_to) begin
                r_phi   <= '0;
                r_nosig <= 1'b1;
                r_vld   <= 1'b1;
                r_cnt   <= '0;
                r_armed <= 1'b0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end

          ST_MEAS: begin
            if (w_acc) begin
              // Final crossing beats a simultaneous timeout.
              if (w_cross && w_last) begin
                if (w_sat) begin
                  r_phi   <= '1;
                  r_nosig <= 1'b0;
                  r_vld   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
                end else begin
                  r_den   <= w_cnt_inc;
                  r_rem   <= {{cntw{1'b0}}, 1'b1};
                  r_quo   <= '0;
                  r_bit   <= BW'(QW);
                  r_busy  <= 1'b1;
                  r_state <= ST_DIV;
                end
              end else if (w_cnt_to) begin
                r_phi   <= '0;
                r_nosig <= 1'b1;
                r_vld   <= 1'b1;
                r_cnt   <= '0;
                r_armed <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_cnt <= w_cnt_inc;
                if (w_cross) r_ncross <= r_ncross + 1'b1;
              end
            end
          end

          ST_DIV: begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_bit <= r_bit - 1'b1;
            // Last quotient bit: publish straight from the step result.
            if (r_bit == BW'(1)) begin
              r_phi   <= w_quo_nx;
              r_nosig <= 1'b0;
              r_vld   <= 1'b1;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i_mtr.phi_inc_o = r_phi;
  assign i_mtr.out_valid = r_vld;
  assign i_mtr.no_sig    = r_nosig;
  assign i_mtr.busy      = r_busy;

endmodule
